// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [1:0] MEM_WR_NONE = 2'b00;
    localparam logic [1:0] MEM_WR_WORD = 2'b11;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs four stream bytes into one little-endian word; used for both the length prefix and data words.
module byte_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    // Only the first three bytes need storage; the fourth completes the word straight from the input.
    logic [23:0] shreg;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (strobe) begin
            cnt   <= cnt + 2'd1;
            shreg <= {data, shreg[23:8]};
        end
    end

    assign word_valid = strobe && (cnt == 2'd3);
    assign word       = {data, shreg};

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian image from a byte stream into instruction memory,
// holding the core in reset until the whole image has been written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          MEM_SIZE  = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [1:0]  mem_wr,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int MAX_WORDS = MEM_SIZE / 4;
    localparam int IDX_W     = $clog2(MAX_WORDS + 1);

    loader_state_t    state, state_nxt;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] word_idx;
    logic             xfer;
    logic             pk_clear;
    logic             pk_valid;
    logic [31:0]      pk_word;
    logic             all_packed;
    logic [31:0]      word_addr;

    assign xfer       = in_valid && in_ready;
    assign all_packed = (word_idx == len_q);
    assign word_addr  = BASE_ADDR + {{(30 - IDX_W){1'b0}}, word_idx, 2'b00};

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .strobe     (xfer),
        .data       (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        pk_clear   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_rst_n = 1'b0;
        unique case (state)
            IDLE, DONE, ERR: begin
                done       = (state == DONE);
                err        = (state == ERR);
                core_rst_n = (state == DONE);
                if (start) begin
                    pk_clear  = 1'b1;
                    state_nxt = LEN;
                end
            end
            LEN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (pk_valid) begin
                    if (pk_word == 32'd0)
                        state_nxt = DONE;
                    else if (pk_word > 32'(MAX_WORDS))
                        state_nxt = ERR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                // Stop accepting once the final word is packed; that cycle carries its write.
                in_ready = !all_packed;
                if (all_packed)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            word_idx    <= '0;
            mem_wr      <= MEM_WR_NONE;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            state  <= state_nxt;
            mem_wr <= MEM_WR_NONE;
            if (pk_clear) begin
                len_q    <= '0;
                word_idx <= '0;
            end
            if (state == LEN && pk_valid)
                len_q <= pk_word[IDX_W-1:0];
            if (state == DATA && pk_valid) begin
                mem_wr      <= MEM_WR_WORD;
                mem_wr_addr <= word_addr;
                mem_wr_data <= pk_word;
                word_idx    <= word_idx + IDX_W'(1);
            end
        end
    end

endmodule
